if_id_stage: RTL and testbench

//   Fetch stage plus IF/ID pipeline register of the pipelined DLX core. Owns the PC and issues instruction-memory requests.

---
 rtl/dlx_pkg.sv | 10 +
 rtl/ifid_skid_buffer.sv | 33 +++
 rtl/if_id_stage.sv | 128 ++++++++++++
 tb/tb_if_id_stage.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dlx_pkg.sv
// dlx_pkg: shared instruction-field constants and fetch FSM encoding for the DLX front end.
package dlx_pkg;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    typedef enum logic [1:0] {START, FETCH, HOLD} fetch_state_t;
endpackage

// File: rtl/ifid_skid_buffer.sv
// ifid_skid_buffer: single-entry {instr, pc} holding register; clear beats load beats drain.
module ifid_skid_buffer
    import dlx_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               drain,
    input  logic               clear,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [PC_W-1:0]    d_pc,
    output logic               full,
    output logic [INSTR_W-1:0] q_instr,
    output logic [PC_W-1:0]    q_pc
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= 1'b0;
            q_instr <= NOP_INSTR;
            q_pc    <= '0;
        end else if (clear) begin
            full    <= 1'b0;
        end else if (load) begin
            full    <= 1'b1;
            q_instr <= d_instr;
            q_pc    <= d_pc;
        end else if (drain) begin
            full    <= 1'b0;
        end
    end
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: DLX fetch stage and IF/ID register with a one-entry stall skid buffer.
// Optional IFID_PERF_EN adds saturating stall/flush performance counters.
module if_id_stage
    import dlx_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               IFflush,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic [PC_W-1:0]    id_pc_plus4,
    output logic [5:0]         Opcode,
    output logic [5:0]         funct
`ifdef IFID_PERF_EN
   ,output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);
    fetch_state_t state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic load_fetch, skid_load, skid_drain, skid_full, kill;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0] skid_pc;

    assign kill      = redirect_valid || IFflush;
    assign imem_req  = state == FETCH;
    assign imem_addr = pc;
    assign Opcode    = id_instr[OPCODE_MSB:OPCODE_LSB];
    assign funct     = id_instr[FUNCT_MSB:FUNCT_LSB];

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        load_fetch = 1'b0;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        case (state)
            START: state_nxt = FETCH;
            FETCH: if (imem_ready) begin
                pc_nxt     = pc + PC_W'(4);
                load_fetch = !stall;
                skid_load  = stall;
                state_nxt  = stall ? HOLD : FETCH;
            end
            HOLD: if (!stall) begin
                skid_drain = 1'b1;
                state_nxt  = FETCH;
            end
            default: state_nxt = START;
        endcase
        // A flush or redirect discards any same-cycle response, so nothing is consumed
        if (kill) begin
            pc_nxt     = redirect_valid ? {redirect_pc[PC_W-1:2], 2'b00} : pc;
            load_fetch = 1'b0;
            skid_load  = 1'b0;
            skid_drain = 1'b0;
            state_nxt  = FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= START;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    ifid_skid_buffer #(.PC_W(PC_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (skid_load),
        .drain   (skid_drain),
        .clear   (kill),
        .d_instr (imem_rdata),
        .d_pc    (pc),
        .full    (skid_full),
        .q_instr (skid_instr),
        .q_pc    (skid_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid    <= 1'b0;
            id_instr    <= NOP_INSTR;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
        end else if (kill) begin
            id_valid    <= 1'b0;
            id_instr    <= NOP_INSTR;
        end else if (load_fetch) begin
            id_valid    <= 1'b1;
            id_instr    <= imem_rdata;
            id_pc       <= pc;
            id_pc_plus4 <= pc + PC_W'(4);
        end else if (skid_drain) begin
            id_valid    <= skid_full;
            id_instr    <= skid_full ? skid_instr : NOP_INSTR;
            id_pc       <= skid_pc;
            id_pc_plus4 <= skid_pc + PC_W'(4);
        end
    end

`ifdef IFID_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall && id_valid && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (kill && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: vector table plus scoreboard bench for if_id_stage.
module tb_if_id_stage;
    logic clk = 1'b0;
    logic rst_n;
    logic imem_req, imem_ready, stall, IFflush, redirect_valid, id_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, id_instr, id_pc, id_pc_plus4;
    logic [5:0] Opcode, funct;
`ifdef IFID_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif
    logic [31:0] mem [256];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    assign imem_rdata = mem[imem_addr[9:2]];

    if_id_stage #(.PC_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall), .IFflush(IFflush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_valid(id_valid),
        .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .Opcode(Opcode), .funct(funct)
`ifdef IFID_PERF_EN
       ,.perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    typedef struct {
        logic        stall, flush, redir;
        logic [31:0] rpc;
        logic        ready;
        logic        valid;
        logic [31:0] pc;
        logic        req;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs [26];
    vec_t sbq [$];
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_id(input string tag, input logic [31:0] pc);
        logic [31:0] w;
        w = mem[pc[9:2]];
        chk({tag, " id_valid"}, {31'd0, id_valid}, 32'd1);
        chk({tag, " id_pc"}, id_pc, pc);
        chk({tag, " id_instr"}, id_instr, w);
        chk({tag, " id_pc_plus4"}, id_pc_plus4, pc + 32'd4);
        chk({tag, " Opcode"}, {26'd0, Opcode}, {26'd0, w[31:26]});
        chk({tag, " funct"}, {26'd0, funct}, {26'd0, w[5:0]});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " imem_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, " id_valid"}, {31'd0, id_valid}, 32'd0);
        chk({tag, " id_instr"}, id_instr, 32'd0);
        chk({tag, " id_pc"}, id_pc, 32'd0);
        chk({tag, " id_pc_plus4"}, id_pc_plus4, 32'd0);
        chk({tag, " Opcode"}, {26'd0, Opcode}, 32'd0);
        chk({tag, " funct"}, {26'd0, funct}, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t v(logic s, logic f, logic r, logic [31:0] rpc, logic rdy,
                               logic val, logic [31:0] pc, logic req, logic [31:0] addr);
        vec_t x;
        x.stall = s; x.flush = f; x.redir = r; x.rpc = rpc; x.ready = rdy;
        x.valid = val; x.pc = pc; x.req = req; x.addr = addr;
        return x;
    endfunction

    initial begin
        vec_t e;
        logic [31:0] exp_pc, last_pc;
        for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h9E37_79B9 + 32'h1234_5679;
        mem[0] = 32'h2001_0005;
        mem[1] = 32'h0022_1820;
        vecs[0]  = v(0,0,0,0,1,             1,32'h8,1,32'hC);
        vecs[1]  = v(1,0,0,0,1,             1,32'h8,0,32'h10);
        vecs[2]  = v(1,0,0,0,1,             1,32'h8,0,32'h10);
        vecs[3]  = v(1,0,0,0,1,             1,32'h8,0,32'h10);
        vecs[4]  = v(0,0,0,0,1,             1,32'hC,1,32'h10);
        vecs[5]  = v(0,0,0,0,1,             1,32'h10,1,32'h14);
        vecs[6]  = v(0,0,0,0,0,             1,32'h10,1,32'h14);
        vecs[7]  = v(0,0,0,0,0,             1,32'h10,1,32'h14);
        vecs[8]  = v(0,0,0,0,0,             1,32'h10,1,32'h14);
        vecs[9]  = v(0,0,0,0,0,             1,32'h10,1,32'h14);
        vecs[10] = v(0,0,0,0,1,             1,32'h14,1,32'h18);
        vecs[11] = v(1,1,0,0,1,             0,32'h0,1,32'h18);
        vecs[12] = v(0,0,0,0,1,             1,32'h18,1,32'h1C);
        vecs[13] = v(0,0,1,32'h103,1,       0,32'h0,1,32'h100);
        vecs[14] = v(0,0,0,0,1,             1,32'h100,1,32'h104);
        vecs[15] = v(1,0,0,0,0,             1,32'h100,1,32'h104);
        vecs[16] = v(0,0,0,0,1,             1,32'h104,1,32'h108);
        vecs[17] = v(1,0,0,0,1,             1,32'h104,0,32'h10C);
        vecs[18] = v(1,1,0,0,0,             0,32'h0,1,32'h10C);
        vecs[19] = v(0,0,0,0,1,             1,32'h10C,1,32'h110);
        vecs[20] = v(0,0,1,32'hFFFF_FFFF,0, 0,32'h0,1,32'hFFFF_FFFC);
        vecs[21] = v(0,0,0,0,1,             1,32'hFFFF_FFFC,1,32'h0);
        vecs[22] = v(0,0,0,0,1,             1,32'h0,1,32'h4);
        vecs[23] = v(1,0,0,0,1,             1,32'h0,0,32'h8);
        vecs[24] = v(1,0,1,32'h200,0,       0,32'h0,1,32'h200);
        vecs[25] = v(0,0,0,0,1,             1,32'h200,1,32'h204);

        rst_n = 1'b0; stall = 0; IFflush = 0; redirect_valid = 0; redirect_pc = 0; imem_ready = 1;
        #12;
        chk_zero("reset");
        rst_n = 1'b1;
        tick();
        chk("start imem_req", {31'd0, imem_req}, 32'd1);
        chk("start imem_addr", imem_addr, 32'h0);
        chk("start id_valid", {31'd0, id_valid}, 32'd0);
        tick();
        chk_id("first", 32'h0);
        chk("first Opcode", {26'd0, Opcode}, 32'h08);
        tick();
        chk_id("second", 32'h4);
        chk("second funct", {26'd0, funct}, 32'h20);

        foreach (vecs[i]) begin
            stall = vecs[i].stall; IFflush = vecs[i].flush; redirect_valid = vecs[i].redir;
            redirect_pc = vecs[i].rpc; imem_ready = vecs[i].ready;
            sbq.push_back(vecs[i]);
            tick();
            e = sbq.pop_front();
            chk($sformatf("v%0d imem_req", i), {31'd0, imem_req}, {31'd0, e.req});
            chk($sformatf("v%0d imem_addr", i), imem_addr, e.addr);
            if (e.valid) chk_id($sformatf("v%0d", i), e.pc);
            else begin
                chk($sformatf("v%0d id_valid", i), {31'd0, id_valid}, 32'd0);
                chk($sformatf("v%0d id_instr", i), id_instr, 32'd0);
            end
        end

        stall = 0; IFflush = 0; redirect_valid = 0;
        exp_pc = 32'h204; last_pc = 32'h200;
        for (int c = 0; c < 40; c++) begin
            imem_ready = 1'($urandom_range(0, 1));
            if (imem_ready) begin
                exp_q.push_back(exp_pc);
                exp_pc += 32'd4;
            end
            tick();
            if (exp_q.size() != 0) last_pc = exp_q.pop_front();
            chk_id($sformatf("rnd%0d", c), last_pc);
            chk($sformatf("rnd%0d imem_addr", c), imem_addr, exp_pc);
        end

        stall = 1; imem_ready = 1;
        tick();
        chk("hold imem_req", {31'd0, imem_req}, 32'd0);
        #2 rst_n = 1'b0;
        #1 chk_zero("async reset");
        stall = 0;
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk("rerun imem_req", {31'd0, imem_req}, 32'd1);
        chk("rerun imem_addr", imem_addr, 32'h0);
        chk("rerun id_valid", {31'd0, id_valid}, 32'd0);
        tick();
        chk_id("rerun", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
